// File: rtl/flash_read_cache_pkg.sv
// Shared types and address-split width helpers for the flash read cache.
package flash_read_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_FILL    = 2'd2,
    ST_RESPOND = 2'd3
  } cache_state_t;

  function automatic int off_width(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  // Byte address = {tag, index, word offset, 2 byte bits}.
  function automatic int tag_width(input int addr_w, input int line_words, input int lines);
    return addr_w - 2 - $clog2(line_words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/flash_read_cache_line_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module flash_read_cache_line_ram
  import flash_read_cache_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // No reset on the array or read register so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/flash_read_cache.sv
// Read-only direct-mapped line cache between the CPU memory bus and the
// SPI flash reader; misses fetch a whole line as one burst.
module flash_read_cache
  import flash_read_cache_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  input  logic              flush,
  output logic              fl_start,
  output logic [ADDR_W-1:0] fl_address,
  output logic [23:0]       fl_word_count,
  input  logic              fl_strobe,
  input  logic [31:0]       fl_data,
  input  logic              fl_done
);

  localparam int OFF_W = off_width(LINE_WORDS);
  localparam int IDX_W = idx_width(LINES);
  localparam int TAG_W = tag_width(ADDR_W, LINE_WORDS, LINES);
  localparam int CNT_W = OFF_W + 1;

  cache_state_t       r_state;
  logic [TAG_W-1:0]   r_tag;
  logic [IDX_W-1:0]   r_idx;
  logic [OFF_W-1:0]   r_off;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_flush_pend;

  logic [IDX_W-1:0]   w_req_idx;
  logic [OFF_W-1:0]   w_req_off;
  logic [TAG_W-1:0]   w_tag_q;
  logic [31:0]        w_data_q;
  logic [LINES-1:0]   w_valid;
  logic               w_hit;
  logic               w_take;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_fill_done;
  logic               w_tag_we;
  logic               w_flush_apply;
  logic               w_miss_clr;
  logic               w_unused;

  assign w_req_idx = mem_addr[2+OFF_W +: IDX_W];
  assign w_req_off = mem_addr[2 +: OFF_W];
  assign w_unused  = ^mem_addr[1:0];

  assign w_hit         = w_valid[r_idx] && (w_tag_q == r_tag);
  assign w_take        = (r_state == ST_FILL) && fl_strobe && (r_cnt < CNT_W'(LINE_WORDS));
  assign w_cnt_next    = r_cnt + {{(CNT_W-1){1'b0}}, w_take};
  assign w_fill_done   = (r_state == ST_FILL) && fl_done;
  // A short burst leaves the line invalid; only a complete line gets its tag.
  assign w_tag_we      = w_fill_done && (w_cnt_next == CNT_W'(LINE_WORDS));
  assign w_flush_apply = (r_state == ST_IDLE) && !mem_valid && r_flush_pend;
  assign w_miss_clr    = (r_state == ST_LOOKUP) && !w_hit;

  assign fl_word_count = 24'(LINE_WORDS);

  // The read side always follows the live request address; its output is
  // only consumed in LOOKUP, one edge after the request was accepted.
  flash_read_cache_line_ram #(
    .DATA_W (32),
    .DEPTH  (LINES * LINE_WORDS)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_take),
    .i_waddr ({r_idx, r_cnt[OFF_W-1:0]}),
    .i_wdata (fl_data),
    .i_raddr ({w_req_idx, w_req_off}),
    .o_rdata (w_data_q)
  );

  flash_read_cache_line_ram #(
    .DATA_W (TAG_W),
    .DEPTH  (LINES)
  ) u_tag_ram (
    .clk     (clk),
    .i_we    (w_tag_we),
    .i_waddr (r_idx),
    .i_wdata (r_tag),
    .i_raddr (w_req_idx),
    .o_rdata (w_tag_q)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      logic r_v;
      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          r_v <= 1'b0;
        end else if (w_flush_apply) begin
          r_v <= 1'b0;
        end else if (r_idx == IDX_W'(gi)) begin
          if (w_miss_clr) begin
            r_v <= 1'b0;
          end else if (w_tag_we) begin
            r_v <= 1'b1;
          end
        end
      end
      assign w_valid[gi] = r_v;
    end
  endgenerate

  // A new flush wins over clearing, so a pulse during the apply cycle is kept.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_flush_pend <= 1'b0;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end else if (w_flush_apply) begin
      r_flush_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= ST_IDLE;
      r_tag      <= '0;
      r_idx      <= '0;
      r_off      <= '0;
      r_cnt      <= '0;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      fl_start   <= 1'b0;
      fl_address <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_valid) begin
            r_tag   <= mem_addr[ADDR_W-1 -: TAG_W];
            r_idx   <= w_req_idx;
            r_off   <= w_req_off;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            mem_rdata <= w_data_q;
            mem_ready <= 1'b1;
            r_state   <= ST_RESPOND;
          end else begin
            fl_start   <= 1'b1;
            fl_address <= {r_tag, r_idx, {(OFF_W+2){1'b0}}};
            r_cnt      <= '0;
            r_state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_take) begin
            r_cnt <= w_cnt_next;
            if (r_cnt[OFF_W-1:0] == r_off) begin
              mem_rdata <= fl_data;
            end
          end
          if (fl_done) begin
            fl_start  <= 1'b0;
            mem_ready <= 1'b1;
            r_state   <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_cache.sv
// Directed bench for flash_read_cache: CPU reader plus a scripted flash model.
module tb_flash_read_cache;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        fl_start;
  logic [23:0] fl_address;
  logic [23:0] fl_word_count;
  logic        fl_strobe;
  logic [31:0] fl_data;
  logic        fl_done;

  always #5 clk = ~clk;

  flash_read_cache dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .flush         (flush),
    .fl_start      (fl_start),
    .fl_address    (fl_address),
    .fl_word_count (fl_word_count),
    .fl_strobe     (fl_strobe),
    .fl_data       (fl_data),
    .fl_done       (fl_done)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Flash words are {generation, byte address} so every refetch is distinguishable.
  logic [7:0]  gen;
  logic [31:0] r_data;
  int          r_cycles;
  int          r_bursts;
  logic [23:0] r_baddr;
  logic [23:0] r_bcnt;
  int          r_done_lat;
  bit          r_timeout;

  task automatic cpu_read(input logic [23:0] addr, input int n_strb, input bit done_late,
                          input bit flush_mid, input int idle);
    int  k;
    int  done_cyc;
    bit  in_burst;
    bit  got;
    repeat (idle + 1) @(negedge clk);
    r_data = 'x; r_cycles = 0; r_bursts = 0; r_baddr = 'x; r_bcnt = 'x;
    r_done_lat = -1; r_timeout = 0;
    k = 0; done_cyc = -1; in_burst = 0; got = 0;
    mem_addr = addr;
    mem_valid = 1'b1;
    while (!got) begin
      @(negedge clk);
      r_cycles++;
      fl_strobe = 1'b0; fl_done = 1'b0; flush = 1'b0;
      if (mem_ready) begin
        r_data = mem_rdata;
        r_done_lat = r_cycles - done_cyc;
        mem_valid = 1'b0;
        got = 1;
      end else if (r_cycles > 100) begin
        $display("FAIL read_timeout: addr %h got no mem_ready, required within 100 cycles", addr);
        r_timeout = 1;
        mem_valid = 1'b0;
        got = 1;
      end else if (fl_start) begin
        if (!in_burst) begin
          in_burst = 1; r_bursts++; r_baddr = fl_address; r_bcnt = fl_word_count;
        end
        if (k < n_strb) begin
          fl_strobe = 1'b1;
          fl_data = {gen, r_baddr + 24'(4 * k)};
          if (k == n_strb - 1 && !done_late) begin
            fl_done = 1'b1; done_cyc = r_cycles;
          end
          k++;
          if (flush_mid && k == 2) flush = 1'b1;
        end else if (k == n_strb) begin
          fl_done = 1'b1; done_cyc = r_cycles;
          k++;
        end
      end
    end
    $display("read addr=%h strobes=%0d bursts=%0d burst_addr=%h data=%h cycles=%0d",
             addr, n_strb, r_bursts, r_baddr, r_data, r_cycles);
  endtask

  task automatic test_reset();
    n_vec++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b required 0", mem_ready); end
    n_vec++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h required 0", mem_rdata); end
    n_vec++; if (fl_start !== 1'b0) begin n_bad++; $display("FAIL reset_fl_start: got %b required 0", fl_start); end
    n_vec++; if (fl_address !== 24'h0) begin n_bad++; $display("FAIL reset_fl_address: got %h required 0", fl_address); end
    n_vec++; if (fl_word_count !== 24'd4) begin n_bad++; $display("FAIL word_count: got %0d required 4", fl_word_count); end
    $display("reset checked");
  endtask

  task automatic test_cold_miss();
    gen = 8'h01;
    cpu_read(24'h000104, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 1) begin n_bad++; $display("FAIL cold_bursts: got %0d required 1", r_bursts); end
    n_vec++; if (r_baddr !== 24'h000100) begin n_bad++; $display("FAIL cold_baddr: got %h required 000100", r_baddr); end
    n_vec++; if (r_bcnt !== 24'd4) begin n_bad++; $display("FAIL cold_count: got %0d required 4", r_bcnt); end
    n_vec++; if (r_data !== 32'h01000104) begin n_bad++; $display("FAIL cold_data: got %h required 01000104", r_data); end
    n_vec++; if (r_done_lat !== 1) begin n_bad++; $display("FAIL cold_ready_lat: got %0d required 1", r_done_lat); end
  endtask

  task automatic test_hit();
    gen = 8'h02;
    cpu_read(24'h000108, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 0) begin n_bad++; $display("FAIL hit_bursts: got %0d required 0", r_bursts); end
    n_vec++; if (r_cycles !== 2) begin n_bad++; $display("FAIL hit_latency: got %0d required 2", r_cycles); end
    n_vec++; if (r_data !== 32'h01000108) begin n_bad++; $display("FAIL hit_data: got %h required 01000108", r_data); end
    @(negedge clk);
    n_vec++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL ready_pulse: got %b required 0", mem_ready); end
  endtask

  task automatic test_conflict();
    gen = 8'h03;
    cpu_read(24'h000300, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 1 || r_data !== 32'h03000300) begin n_bad++; $display("FAIL conflict_a: got %0d/%h required 1/03000300", r_bursts, r_data); end
    gen = 8'h04;
    cpu_read(24'h001304, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 1 || r_baddr !== 24'h001300) begin n_bad++; $display("FAIL conflict_b_burst: got %0d/%h required 1/001300", r_bursts, r_baddr); end
    n_vec++; if (r_data !== 32'h04001304) begin n_bad++; $display("FAIL conflict_b_data: got %h required 04001304", r_data); end
    gen = 8'h05;
    cpu_read(24'h000300, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 1 || r_data !== 32'h05000300) begin n_bad++; $display("FAIL conflict_c: got %0d/%h required 1/05000300", r_bursts, r_data); end
  endtask

  task automatic test_flush();
    gen = 8'h06;
    cpu_read(24'h000200, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 1 || r_data !== 32'h06000200) begin n_bad++; $display("FAIL flush_fill: got %0d/%h required 1/06000200", r_bursts, r_data); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    gen = 8'h07;
    cpu_read(24'h000204, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 1 || r_data !== 32'h07000204) begin n_bad++; $display("FAIL flush_refetch: got %0d/%h required 1/07000204", r_bursts, r_data); end
    gen = 8'h08;
    cpu_read(24'h000400, 4, 0, 1, 2);
    n_vec++; if (r_bursts !== 1 || r_data !== 32'h08000400) begin n_bad++; $display("FAIL flush_mid_fill: got %0d/%h required 1/08000400", r_bursts, r_data); end
    gen = 8'h09;
    cpu_read(24'h000404, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 1 || r_data !== 32'h09000404) begin n_bad++; $display("FAIL flush_mid_after: got %0d/%h required 1/09000404", r_bursts, r_data); end
  endtask

  task automatic test_short_burst();
    gen = 8'h0A;
    cpu_read(24'h000504, 2, 1, 0, 2);
    n_vec++; if (r_data !== 32'h0A000504) begin n_bad++; $display("FAIL short_data: got %h required 0A000504", r_data); end
    n_vec++; if (r_done_lat !== 1) begin n_bad++; $display("FAIL short_ready_lat: got %0d required 1", r_done_lat); end
    gen = 8'h0B;
    cpu_read(24'h000500, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 1 || r_data !== 32'h0B000500) begin n_bad++; $display("FAIL short_refetch: got %0d/%h required 1/0B000500", r_bursts, r_data); end
  endtask

  task automatic test_long_burst();
    gen = 8'h0C;
    cpu_read(24'h000608, 6, 0, 0, 2);
    n_vec++; if (r_data !== 32'h0C000608) begin n_bad++; $display("FAIL long_data: got %h required 0C000608", r_data); end
    gen = 8'h0D;
    cpu_read(24'h000600, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 0 || r_data !== 32'h0C000600) begin n_bad++; $display("FAIL long_extra_ignored: got %0d/%h required 0/0C000600", r_bursts, r_data); end
  endtask

  task automatic test_back_to_back();
    gen = 8'h0E;
    cpu_read(24'h000604, 4, 0, 0, 0);
    n_vec++; if (r_cycles !== 2 || r_data !== 32'h0C000604) begin n_bad++; $display("FAIL b2b_first: got %0d/%h required 2/0C000604", r_cycles, r_data); end
    cpu_read(24'h00060C, 4, 0, 0, 0);
    n_vec++; if (r_cycles !== 2 || r_data !== 32'h0C00060C) begin n_bad++; $display("FAIL b2b_second: got %0d/%h required 2/0C00060C", r_cycles, r_data); end
  endtask

  task automatic test_reset_mid_fill();
    gen = 8'h0F;
    @(negedge clk);
    mem_addr = 24'h000704;
    mem_valid = 1'b1;
    for (int i = 0; i < 20 && !fl_start; i++) @(negedge clk);
    n_vec++; if (fl_start !== 1'b1) begin n_bad++; $display("FAIL rst_burst_start: got %b required 1", fl_start); end
    fl_strobe = 1'b1; fl_data = {gen, 24'h000700};
    @(negedge clk); fl_data = {gen, 24'h000704};
    @(negedge clk);
    fl_strobe = 1'b0; mem_valid = 1'b0; n_reset = 1'b0;
    #1;
    n_vec++; if (fl_start !== 1'b0) begin n_bad++; $display("FAIL rst_fl_start_async: got %b required 0", fl_start); end
    n_vec++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h required 0", mem_rdata); end
    @(negedge clk); n_reset = 1'b1;
    $display("reset asserted mid-fill after 2 strobes");
    gen = 8'h10;
    cpu_read(24'h000704, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 1 || r_data !== 32'h10000704) begin n_bad++; $display("FAIL rst_refetch: got %0d/%h required 1/10000704", r_bursts, r_data); end
    gen = 8'h11;
    cpu_read(24'h000608, 4, 0, 0, 2);
    n_vec++; if (r_bursts !== 1 || r_data !== 32'h11000608) begin n_bad++; $display("FAIL rst_invalidates: got %0d/%h required 1/11000608", r_bursts, r_data); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset = 1'b0; mem_valid = 1'b0; mem_addr = '0; flush = 1'b0;
    fl_strobe = 1'b0; fl_data = '0; fl_done = 1'b0; gen = '0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_short_burst();
    test_long_burst();
    test_back_to_back();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
